// File: rtl/reg_sync_pkg.sv
// Shared defaults and channel map for the frame-synchronised register banks.
package reg_sync_pkg;

  localparam int unsigned CH_NUM_DEF  = 8;
  localparam int unsigned REG_WD_DEF  = 32;
  localparam int unsigned ADDR_WD_DEF = 3;
  localparam int unsigned CNT_WD_DEF  = 16;

  localparam int unsigned CH_PIXEL_FORMAT = 0;
  localparam int unsigned CH_TEST_IMAGE   = 1;
  localparam int unsigned CH_PULSE_FILTER = 2;
  localparam int unsigned CH_ROI_WIDTH    = 3;
  localparam int unsigned CH_ENCRYPT      = 4;

endpackage

// File: rtl/frame_edge_det.sv
// Frame boundary detector: flags the falling edge of frame valid, combinationally on the input.
module frame_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_fval,
  output logic o_fe_c
);

  logic fval_d;

  // Resetting to 0 means reset release can never look like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fval_d <= 1'b0;
    else          fval_d <= i_fval;
  end

  assign o_fe_c = fval_d & ~i_fval;

endmodule

// File: rtl/reg_frame_sync_bank.sv
// Shadow/active register bank; pending shadows commit at frame end or on force, per-channel bypass.
module reg_frame_sync_bank
  import reg_sync_pkg::*;
#(
  parameter int unsigned CH_NUM  = CH_NUM_DEF,
  parameter int unsigned REG_WD  = REG_WD_DEF,
  parameter int unsigned ADDR_WD = ADDR_WD_DEF,
  parameter int unsigned CNT_WD  = CNT_WD_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic [ADDR_WD-1:0]       iv_wr_addr,
  input  logic [REG_WD-1:0]        iv_wr_data,
  input  logic [CH_NUM-1:0]        iv_imm_mask,
  input  logic                     i_fval,
  input  logic                     i_update_hold,
  input  logic                     i_force_update,
  output logic [CH_NUM*REG_WD-1:0] ov_reg_active,
  output logic [CH_NUM-1:0]        ov_pending,
  output logic                     o_update_pulse,
  output logic                     o_wr_err,
  output logic [CNT_WD-1:0]        ov_update_cnt
);

  logic fe_c;
  logic addr_ok_c;
  logic wr_ok_c;
  logic commit_c;

  frame_edge_det u_frame_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .i_fval  (i_fval),
    .o_fe_c  (fe_c)
  );

  assign addr_ok_c = (32'(iv_wr_addr) < CH_NUM);
  assign wr_ok_c   = i_wr_en & addr_ok_c;
  // Force wins over hold; an edge seen during hold is simply dropped.
  assign commit_c  = (fe_c & ~i_update_hold) | i_force_update;

  logic [REG_WD-1:0] shadow_q [CH_NUM];
  logic [REG_WD-1:0] active_q [CH_NUM];
  logic              pend_q   [CH_NUM];

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    logic sel_c;
    assign sel_c = wr_ok_c & (iv_wr_addr == ADDR_WD'(n));

    // A write coinciding with a commit goes straight to active so it is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
        pend_q[n]   <= 1'b0;
      end else if (sel_c && iv_imm_mask[n]) begin
        shadow_q[n] <= iv_wr_data;
        active_q[n] <= iv_wr_data;
        pend_q[n]   <= 1'b0;
      end else if (sel_c) begin
        shadow_q[n] <= iv_wr_data;
        if (commit_c) begin
          active_q[n] <= iv_wr_data;
          pend_q[n]   <= 1'b0;
        end else begin
          pend_q[n]   <= 1'b1;
        end
      end else if (commit_c && pend_q[n]) begin
        active_q[n] <= shadow_q[n];
        pend_q[n]   <= 1'b0;
      end
    end

    assign ov_reg_active[n*REG_WD +: REG_WD] = active_q[n];
    assign ov_pending[n]                     = pend_q[n];
  end

  // Commit pulse, error pulse and wrapping commit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_update_pulse <= 1'b0;
      o_wr_err       <= 1'b0;
      ov_update_cnt  <= '0;
    end else begin
      o_update_pulse <= commit_c;
      o_wr_err       <= i_wr_en & ~addr_ok_c;
      if (commit_c) ov_update_cnt <= ov_update_cnt + CNT_WD'(1);
    end
  end

endmodule
